bcd_time_counter: RTL and testbench

//  Timekeeping core of the digital clock. Divides the system clock to a 1 s

---
 rtl/bcd_time_counter.sv | 151 +++++++++++++++
 tb/tb_bcd_time_counter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// HH:MM:SS timekeeping core: 1 s prescaler, six BCD digit counters and a range-checked set port.
// Optional CLOCK_12H_EN macro converts the displayed hour to 12 h format and drives pm.
module bcd_time_counter #(
  parameter int DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       set_valid,
  input  logic [7:0] set_hours,
  input  logic [7:0] set_minutes,
  output logic       set_err,
  output logic [3:0] sec_units,
  output logic [3:0] sec_tens,
  output logic [3:0] min_units,
  output logic [3:0] min_tens,
  output logic [3:0] hour_units,
  output logic [3:0] hour_tens,
  output logic       pm,
  output logic       sec_tick,
  output logic       day_roll
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] presc, presc_nxt;
  logic [3:0] hr_units, hr_tens;
  logic [3:0] su_nxt, st_nxt, mu_nxt, mt_nxt, hu_nxt, ht_nxt;
  logic       err_nxt, tick_nxt, roll_nxt;
  logic       set_ok, tick;

  assign set_ok = (set_hours[3:0] <= 4'd9) && (set_hours[7:4] <= 4'd9) &&
                  (set_minutes[3:0] <= 4'd9) && (set_minutes[7:4] <= 4'd9) &&
                  (set_hours <= 8'h23) && (set_minutes <= 8'h59);
  assign tick = run && (presc == LAST);

  // A set strobe always takes priority over a coincident tick; a rejected set freezes everything.
  always_comb begin
    presc_nxt = presc;
    su_nxt    = sec_units;
    st_nxt    = sec_tens;
    mu_nxt    = min_units;
    mt_nxt    = min_tens;
    hu_nxt    = hr_units;
    ht_nxt    = hr_tens;
    err_nxt   = 1'b0;
    tick_nxt  = 1'b0;
    roll_nxt  = 1'b0;
    if (set_valid) begin
      if (set_ok) begin
        presc_nxt = '0;
        su_nxt    = 4'd0;
        st_nxt    = 4'd0;
        mu_nxt    = set_minutes[3:0];
        mt_nxt    = set_minutes[7:4];
        hu_nxt    = set_hours[3:0];
        ht_nxt    = set_hours[7:4];
      end else begin
        err_nxt = 1'b1;
      end
    end else if (tick) begin
      presc_nxt = '0;
      tick_nxt  = 1'b1;
      if (sec_units != 4'd9) su_nxt = sec_units + 4'd1;
      else begin
        su_nxt = 4'd0;
        if (sec_tens != 4'd5) st_nxt = sec_tens + 4'd1;
        else begin
          st_nxt = 4'd0;
          if (min_units != 4'd9) mu_nxt = min_units + 4'd1;
          else begin
            mu_nxt = 4'd0;
            if (min_tens != 4'd5) mt_nxt = min_tens + 4'd1;
            else begin
              mt_nxt = 4'd0;
              if (hr_tens == 4'd2 && hr_units == 4'd3) begin
                ht_nxt   = 4'd0;
                hu_nxt   = 4'd0;
                roll_nxt = 1'b1;
              end else if (hr_units == 4'd9) begin
                hu_nxt = 4'd0;
                ht_nxt = hr_tens + 4'd1;
              end else begin
                hu_nxt = hr_units + 4'd1;
              end
            end
          end
        end
      end
    end else if (run) begin
      presc_nxt = presc + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      sec_units <= 4'd0;
      sec_tens  <= 4'd0;
      min_units <= 4'd0;
      min_tens  <= 4'd0;
      hr_units  <= 4'd0;
      hr_tens   <= 4'd0;
      set_err   <= 1'b0;
      sec_tick  <= 1'b0;
      day_roll  <= 1'b0;
    end else begin
      presc     <= presc_nxt;
      sec_units <= su_nxt;
      sec_tens  <= st_nxt;
      min_units <= mu_nxt;
      min_tens  <= mt_nxt;
      hr_units  <= hu_nxt;
      hr_tens   <= ht_nxt;
      set_err   <= err_nxt;
      sec_tick  <= tick_nxt;
      day_roll  <= roll_nxt;
    end
  end

`ifdef CLOCK_12H_EN
  logic [4:0] hour_bin;
  logic [4:0] disp_bin;

  // Display hour is derived from the next internal hour so it lands on the same edge.
  always_comb begin
    hour_bin = 5'(ht_nxt) * 5'd10 + 5'(hu_nxt);
    if (hour_bin == 5'd0)       disp_bin = 5'd12;
    else if (hour_bin > 5'd12)  disp_bin = hour_bin - 5'd12;
    else                        disp_bin = hour_bin;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hour_units <= 4'd0;
      hour_tens  <= 4'd0;
      pm         <= 1'b0;
    end else begin
      hour_units <= 4'(disp_bin % 5'd10);
      hour_tens  <= 4'(disp_bin / 5'd10);
      pm         <= (hour_bin >= 5'd12);
    end
  end
`else
  assign hour_units = hr_units;
  assign hour_tens  = hr_tens;
  assign pm         = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Self-checking bench for bcd_time_counter (DIV=4): directed steps plus randomized run/set traffic
// compared every cycle against a seconds-of-day reference model.
module tb_bcd_time_counter;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       set_valid;
  logic [7:0] set_hours;
  logic [7:0] set_minutes;
  logic       set_err;
  logic [3:0] sec_units, sec_tens, min_units, min_tens, hour_units, hour_tens;
  logic       pm, sec_tick, day_roll;

  int checks;
  int failures;

  // Reference state: time of day in seconds plus prescaler phase.
  int tod;
  int pc;
  bit exp_err, exp_tick, exp_roll;
  int roll_count;
  int err_count;

  bcd_time_counter #(.DIV(DIV)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .set_valid(set_valid),
    .set_hours(set_hours), .set_minutes(set_minutes), .set_err(set_err),
    .sec_units(sec_units), .sec_tens(sec_tens), .min_units(min_units),
    .min_tens(min_tens), .hour_units(hour_units), .hour_tens(hour_tens),
    .pm(pm), .sec_tick(sec_tick), .day_roll(day_roll)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOne(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input bit exp_reset);
    int h, m, s, dh;
    bit epm;
    h = tod / 3600;
    m = (tod / 60) % 60;
    s = tod % 60;
`ifdef CLOCK_12H_EN
    dh  = (h == 0) ? 12 : ((h > 12) ? h - 12 : h);
    epm = (h >= 12);
`else
    dh  = h;
    epm = 1'b0;
`endif
    if (exp_reset) begin
      dh  = 0;
      epm = 1'b0;
    end
    checkOne("sec_units",  32'(sec_units),  32'(s % 10));
    checkOne("sec_tens",   32'(sec_tens),   32'(s / 10));
    checkOne("min_units",  32'(min_units),  32'(m % 10));
    checkOne("min_tens",   32'(min_tens),   32'(m / 10));
    checkOne("hour_units", 32'(hour_units), 32'(dh % 10));
    checkOne("hour_tens",  32'(hour_tens),  32'(dh / 10));
    checkOne("pm",         32'(pm),         32'(epm));
    checkOne("sec_tick",   32'(sec_tick),   32'(exp_tick));
    checkOne("day_roll",   32'(day_roll),   32'(exp_roll));
    checkOne("set_err",    32'(set_err),    32'(exp_err));
  endtask

  // Drives one cycle of inputs, advances the model by the same edge, then checks after the edge.
  task automatic applyStimulus(input bit r, input bit sv, input logic [7:0] sh, input logic [7:0] sm);
    int ht, hu, mt, mu;
    bit ok;
    run = r;
    set_valid = sv;
    set_hours = sh;
    set_minutes = sm;
    exp_err = 1'b0;
    exp_tick = 1'b0;
    exp_roll = 1'b0;
    if (sv) begin
      ht = int'(sh[7:4]); hu = int'(sh[3:0]);
      mt = int'(sm[7:4]); mu = int'(sm[3:0]);
      ok = (ht <= 9) && (hu <= 9) && (mt <= 9) && (mu <= 9) &&
           (ht * 10 + hu < 24) && (mt * 10 + mu < 60);
      if (ok) begin
        tod = (ht * 10 + hu) * 3600 + (mt * 10 + mu) * 60;
        pc = 0;
      end else begin
        exp_err = 1'b1;
        err_count++;
      end
    end else if (r) begin
      if (pc == DIV - 1) begin
        pc = 0;
        tod = tod + 1;
        exp_tick = 1'b1;
        if (tod == 86400) begin
          tod = 0;
          exp_roll = 1'b1;
          roll_count++;
        end
      end else begin
        pc = pc + 1;
      end
    end
    @(posedge clk);
    #1;
    checkOutput(1'b0);
  endtask

  task automatic doSet(input bit r, input logic [7:0] sh, input logic [7:0] sm);
    applyStimulus(r, 1'b1, sh, sm);
    applyStimulus(r, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic resetModel();
    tod = 0;
    pc = 0;
    exp_err = 1'b0;
    exp_tick = 1'b0;
    exp_roll = 1'b0;
  endtask

  initial begin
    int snap_tod;
    int snap_pc;
    logic [7:0] rh, rm;
    checks = 0;
    failures = 0;
    roll_count = 0;
    err_count = 0;
    rst_n = 1'b0;
    run = 1'b0;
    set_valid = 1'b0;
    set_hours = 8'h00;
    set_minutes = 8'h00;
    resetModel();
    repeat (2) @(posedge clk);
    #1;
    checkOutput(1'b0);
    rst_n = 1'b1;

    // Free run from reset: ten seconds.
    for (int i = 0; i < 40; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    checkOne("ten_seconds", 32'(tod), 32'd10);

    // Midnight rollover.
    doSet(1'b1, 8'h23, 8'h59);
    roll_count = 0;
    for (int i = 0; i < 4 * 60; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    checkOne("roll_count", 32'(roll_count), 32'd1);
    checkOne("midnight", 32'(tod), 32'd0);

    // Rejected sets leave time unchanged.
    err_count = 0;
    snap_tod = tod;
    doSet(1'b0, 8'h24, 8'h00);
    doSet(1'b0, 8'h1A, 8'h00);
    doSet(1'b0, 8'h10, 8'h60);
    checkOne("err_count", 32'(err_count), 32'd3);
    checkOne("err_time_kept", 32'(tod), 32'(snap_tod));

    // Set colliding with a tick: run until prescaler sits at DIV-1.
    for (int i = 0; i < 8 && pc != DIV - 1; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    checkOne("pc_at_last", 32'(pc), 32'(DIV - 1));
    applyStimulus(1'b1, 1'b1, 8'h12, 8'h34);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);

    // Freeze and resume.
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    snap_tod = tod;
    snap_pc = pc;
    for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
    checkOne("frozen_tod", 32'(tod), 32'(snap_tod));
    checkOne("frozen_pc", 32'(pc), 32'(snap_pc));
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);

`ifdef CLOCK_12H_EN
    doSet(1'b0, 8'h13, 8'h00);
    checkOne("h12_units_13", 32'(hour_units), 32'd1);
    checkOne("h12_pm_13", 32'(pm), 32'd1);
    doSet(1'b0, 8'h00, 8'h00);
    checkOne("h12_tens_00", 32'(hour_tens), 32'd1);
    checkOne("h12_pm_00", 32'(pm), 32'd0);
`endif

    // Randomized run/set traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          rh = 8'($urandom_range(0, 23));
          rm = 8'($urandom_range(0, 59));
          rh = {4'(rh / 10), 4'(rh % 10)};
          rm = {4'(rm / 10), 4'(rm % 10)};
        end else begin
          rh = 8'($urandom);
          rm = 8'($urandom);
        end
        applyStimulus($urandom_range(0, 3) != 0, 1'b1, rh, rm);
      end else begin
        applyStimulus($urandom_range(0, 7) != 0, 1'b0, 8'h00, 8'h00);
      end
    end

    // Asynchronous reset between edges.
    doSet(1'b1, 8'h21, 8'h47);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    resetModel();
    checkOutput(1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkOutput(1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b0, 8'h00, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
